// File: rtl/axi_lite_master.sv
// AXI4-Lite single-outstanding master.
// Turns one upstream command (read or write) into the matching AXI4-Lite
// channel handshakes. It then returns the read data and response code on the
// rsp channel. Every AXI output and every rsp output comes straight from a
// register.
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    // upstream command
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    // upstream response
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    // write address channel
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    // write data channel
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    // write response channel
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    // read address channel
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic                      arvalid,
    input  logic                      arready,
    // read data channel
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WR_B = 3'd2,
        RD_A = 3'd3,
        RD_D = 3'd4,
        RSP  = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    cmd_ready_s;
    logic                    rsp_valid_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_s;
    logic [1:0]              rsp_resp_s;
    logic [ADDR_WIDTH-1:0]   awaddr_s;
    logic                    awvalid_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic [STRB_WIDTH-1:0]   wstrb_s;
    logic                    wvalid_s;
    logic                    bready_s;
    logic [ADDR_WIDTH-1:0]   araddr_s;
    logic                    arvalid_s;
    logic                    rready_s;

    // Next-state and next-output decode. Every register holds its value unless a handshake moves it.
    always_comb begin
        state_s     = state_r;
        rsp_valid_s = rsp_valid;
        rsp_rdata_s = rsp_rdata;
        rsp_resp_s  = rsp_resp;
        awaddr_s    = awaddr;
        awvalid_s   = awvalid;
        wdata_s     = wdata;
        wstrb_s     = wstrb;
        wvalid_s    = wvalid;
        bready_s    = bready;
        araddr_s    = araddr;
        arvalid_s   = arvalid;
        rready_s    = rready;

        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        awaddr_s  = cmd_addr;
                        wdata_s   = cmd_wdata;
                        wstrb_s   = cmd_wstrb;
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                        state_s   = WR;
                    end else begin
                        araddr_s  = cmd_addr;
                        arvalid_s = 1'b1;
                        state_s   = RD_A;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                // AW and W retire independently; each valid falls right after its own handshake
                awvalid_s = awvalid & ~awready;
                wvalid_s  = wvalid & ~wready;
                if (!awvalid_s && !wvalid_s) begin
                    bready_s = 1'b1;
                    state_s  = WR_B;
                end else begin
                    state_s = WR;
                end
            end
            WR_B: begin
                if (bvalid && bready) begin
                    bready_s    = 1'b0;
                    rsp_resp_s  = bresp;
                    rsp_rdata_s = {DATA_WIDTH{1'b0}};
                    rsp_valid_s = 1'b1;
                    state_s     = RSP;
                end else begin
                    state_s = WR_B;
                end
            end
            RD_A: begin
                if (arvalid && arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = RD_D;
                end else begin
                    state_s = RD_A;
                end
            end
            RD_D: begin
                if (rvalid && rready) begin
                    rready_s    = 1'b0;
                    rsp_rdata_s = rdata;
                    rsp_resp_s  = rresp;
                    rsp_valid_s = 1'b1;
                    state_s     = RSP;
                end else begin
                    state_s = RD_D;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                state_s     = IDLE;
                rsp_valid_s = 1'b0;
                awvalid_s   = 1'b0;
                wvalid_s    = 1'b0;
                bready_s    = 1'b0;
                arvalid_s   = 1'b0;
                rready_s    = 1'b0;
            end
        endcase

        // cmd_ready is registered, so it follows the state that is being entered
        cmd_ready_s = (state_s == IDLE);
    end

    // State and output registers. Reset abandons any in-flight transfer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r   <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
            rsp_resp  <= 2'b00;
            awaddr    <= {ADDR_WIDTH{1'b0}};
            awvalid   <= 1'b0;
            wdata     <= {DATA_WIDTH{1'b0}};
            wstrb     <= {STRB_WIDTH{1'b0}};
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= {ADDR_WIDTH{1'b0}};
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cmd_ready <= cmd_ready_s;
            rsp_valid <= rsp_valid_s;
            rsp_rdata <= rsp_rdata_s;
            rsp_resp  <= rsp_resp_s;
            awaddr    <= awaddr_s;
            awvalid   <= awvalid_s;
            wdata     <= wdata_s;
            wstrb     <= wstrb_s;
            wvalid    <= wvalid_s;
            bready    <= bready_s;
            araddr    <= araddr_s;
            arvalid   <= arvalid_s;
            rready    <= rready_s;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master. A vector table describes each command,
// the slave's ready delays, the response code and how long upstream stalls
// rsp_ready. Expected results are written into the table by hand.
module tb_axi_lite_master;

    logic        aclk;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  resp;
        int          hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] mem  [16];
    int          checks;
    int          failures;
    int          cur_vec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s actual=%h expected=%h", cur_vec, nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
        rsp_ready = 1'b0;
    endtask

    // Issue one command and act as the slave and the upstream consumer until the response is taken.
    task automatic run_txn(input vec_t v);
        int  n;
        int  aw_cnt, w_cnt, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_wait;
        logic done, aw_prev, w_prev;
        logic [3:0] idx;
        idx = v.addr[5:2];
        aw_cnt = 0; w_cnt = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        rsp_wait = 0; done = 1'b0; aw_prev = 1'b0; w_prev = 1'b0;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.data; cmd_wstrb = v.strb;
        n = 0;
        while (!cmd_ready && n < 50) begin
            cycle();
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cycle();
        cmd_valid = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (aw_prev) chk("awvalid_drop", {31'd0, awvalid}, 32'd0);
            if (w_prev)  chk("wvalid_drop", {31'd0, wvalid}, 32'd0);
            if (awvalid) chk("awaddr", awaddr, v.addr);
            if (wvalid) begin
                chk("wdata", wdata, v.data);
                chk("wstrb", {28'd0, wstrb}, {28'd0, v.strb});
            end
            if (arvalid) chk("araddr", araddr, v.addr);
            awready = awvalid && (aw_cnt >= v.aw_dly);
            wready  = wvalid && (w_cnt >= v.w_dly);
            arready = arvalid;
            bvalid  = (aw_hs > 0) && (w_hs > 0) && (b_hs == 0);
            bresp   = v.resp;
            rvalid  = (ar_hs > 0) && (r_hs == 0);
            rresp   = v.resp;
            rdata   = mem[idx];
            if (rsp_valid) begin
                chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, v.exp_resp});
                chk("rsp_rdata", rsp_rdata, v.exp_rdata);
                if (rsp_wait < v.hold) chk("cmd_ready_in_rsp", {31'd0, cmd_ready}, 32'd0);
                rsp_ready = (rsp_wait >= v.hold);
                rsp_wait++;
            end else begin
                rsp_ready = 1'b0;
            end
            aw_prev = awvalid && awready;
            if (aw_prev) aw_hs++;
            if (awvalid) aw_cnt++;
            w_prev = wvalid && wready;
            if (w_prev) begin
                w_hs++;
                for (int b = 0; b < 4; b++)
                    if (v.strb[b]) mem[idx][8*b +: 8] = v.data[8*b +: 8];
            end
            if (wvalid) w_cnt++;
            if (bvalid && bready) b_hs++;
            if (arvalid && arready) ar_hs++;
            if (rvalid && rready) r_hs++;
            if (rsp_valid && rsp_ready) done = 1'b1;
            cycle();
        end
        slave_idle();
        chk("rsp_done", {31'd0, done}, 32'd1);
        chk("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
        chk("aw_hs", aw_hs, v.wr ? 32'd1 : 32'd0);
        chk("w_hs", w_hs, v.wr ? 32'd1 : 32'd0);
        chk("b_hs", b_hs, v.wr ? 32'd1 : 32'd0);
        chk("ar_hs", ar_hs, v.wr ? 32'd0 : 32'd1);
        chk("r_hs", r_hs, v.wr ? 32'd0 : 32'd1);
    endtask

    initial begin
        vec_t extra_w, extra_r;
        int   n;
        checks = 0; failures = 0; cur_vec = -1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        //           wr    addr    data          strb  awd wd resp   hold exp_rdata     exp_resp
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 0, 32'h00000000, 2'b00};
        vecs[1] = '{1'b0, 32'h10, 32'h00000000, 4'h0, 0, 0, 2'b00, 0, 32'hDEADBEEF, 2'b00};
        vecs[2] = '{1'b1, 32'h14, 32'h12345678, 4'h3, 0, 5, 2'b00, 0, 32'h00000000, 2'b00};
        vecs[3] = '{1'b1, 32'h14, 32'hAABBCCDD, 4'h8, 5, 0, 2'b00, 0, 32'h00000000, 2'b00};
        vecs[4] = '{1'b0, 32'h14, 32'h00000000, 4'h0, 0, 0, 2'b00, 1, 32'hAA005678, 2'b00};
        vecs[5] = '{1'b0, 32'h10, 32'h00000000, 4'h0, 0, 0, 2'b10, 3, 32'hDEADBEEF, 2'b10};
        vecs[6] = '{1'b1, 32'h18, 32'h0BADF00D, 4'hF, 2, 1, 2'b11, 2, 32'h00000000, 2'b11};
        vecs[7] = '{1'b0, 32'h18, 32'h00000000, 4'h0, 0, 0, 2'b00, 0, 32'h0BADF00D, 2'b00};
        extra_w = '{1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1, 0, 2'b00, 0, 32'h00000000, 2'b00};
        extra_r = '{1'b0, 32'h20, 32'h00000000, 4'h0, 0, 0, 2'b00, 0, 32'hCAFEF00D, 2'b00};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        slave_idle();

        // Reset state
        areset = 1'b1;
        cycle();
        cycle();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_rsp", {26'd0, wstrb, rsp_resp}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        areset = 1'b0;
        cycle();
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            cur_vec = i;
            run_txn(vecs[i]);
        end

        // Reset while a write address is outstanding
        cur_vec = 100;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24;
        cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 50) begin
            cycle();
            n++;
        end
        cycle();
        cmd_valid = 1'b0;
        cycle();
        chk("mid_awvalid_before", {30'd0, awvalid, wvalid}, 32'd3);
        #2;
        areset = 1'b1;
        #1;
        chk("mid_async_valids", {30'd0, awvalid, wvalid}, 32'd0);
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        cycle();
        cycle();
        areset = 1'b0;
        cycle();
        chk("mid_post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cycle();
        chk("mid_post_quiet", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 32'd0);

        cur_vec = 101;
        run_txn(extra_w);
        cur_vec = 102;
        run_txn(extra_r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width on command and AXI sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; STRB_WIDTH = DATA_WIDTH/8 is derived, not a parameter.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 aclk  in  1  sole clock, all logic on rising edge.
REQ-005 areset  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  upstream command present.
REQ-007 cmd_ready  out  1  block accepts command; high only in IDLE.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data, ignored for reads.
REQ-011 cmd_wstrb  in  STRB_WIDTH  byte strobes, ignored for reads.
REQ-012 rsp_valid  out  1  completion result present.
REQ-013 rsp_ready  in  1  upstream accepts result.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-015 rsp_resp  out  2  bresp or rresp of completed transfer.
REQ-016 awaddr  out  ADDR_WIDTH  write address.
REQ-017 awvalid  out  1  write address valid.
REQ-018 awready  in  1  slave accepts write address.
REQ-019 wdata  out  DATA_WIDTH  write data.
REQ-020 wstrb  out  STRB_WIDTH  write strobes.
REQ-021 wvalid  out  1  write data valid.
REQ-022 wready  in  1  slave accepts write data.
REQ-023 bresp  in  2  write response code.
REQ-024 bvalid  in  1  write response valid.
REQ-025 bready  out  1  master accepts write response.
REQ-026 araddr  out  ADDR_WIDTH  read address.
REQ-027 arvalid  out  1  read address valid.
REQ-028 arready  in  1  slave accepts read address.
REQ-029 rdata  in  DATA_WIDTH  read data.
REQ-030 rresp  in  2  read response code.
REQ-031 rvalid  in  1  read data valid.
REQ-032 rready  out  1  master accepts read data.

Function
REQ-033 SHALL run one FSM: IDLE, WR (AW/W issue), WR_B, RD_A, RD_D, RSP; exactly one transaction outstanding; all AXI and rsp outputs registered.
REQ-034 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, capture addr/wdata/wstrb; write -> next cycle awvalid=wvalid=1, state WR; read -> next cycle arvalid=1, state RD_A.
REQ-035 WR: awvalid drops the cycle after AW handshake, wvalid the cycle after W handshake, independently; AW and W may complete in either order or same cycle; when both done, bready=1, state WR_B.
REQ-036 WR_B: on bvalid&bready, bready=0, rsp_resp=bresp, rsp_rdata=0, rsp_valid=1, state RSP.
REQ-037 RD_A: on arvalid&arready, arvalid=0, rready=1, state RD_D; RD_D: on rvalid&rready, rready=0, rsp_rdata=rdata, rsp_resp=rresp, rsp_valid=1, state RSP.
REQ-038 Any valid, once asserted, SHALL stay high with address/data/strobes stable until its handshake; no valid waits on a ready.
REQ-039 RSP: rsp_valid and rsp fields held until rsp_ready; then rsp_valid=0, state IDLE; next command accepted no earlier than the following cycle (cmd_ready low throughout RSP).
REQ-040 SLVERR/DECERR responses SHALL be forwarded unchanged; no retry, no timeout.

Reset
REQ-041 areset SHALL immediately force IDLE, all valid/ready outputs 0 except cmd_ready=1 on first post-reset edge, awaddr/araddr/wdata/wstrb/rsp_rdata/rsp_resp=0; in-flight transaction abandoned with no rsp_valid.

Verification
REQ-042 Write 0x0000_0010 data 0xDEADBEEF wstrb 0xF, slave OKAY -> one AW and one W handshake, rsp_valid with rsp_resp=0, rsp_rdata=0.
REQ-043 Read back 0x10 -> one AR handshake, rsp_rdata=0xDEADBEEF, rsp_resp=0.
REQ-044 wready delayed 5 cycles after awready -> awvalid drops after AW, wvalid held stable 5 cycles, single B; same with AW delayed.
REQ-045 Slave rresp=2'b10 with rsp_ready low 3 cycles -> rsp_resp=2'b10 held stable, cmd_ready=0 until accepted.
REQ-046 areset asserted while awvalid=1 -> awvalid/wvalid=0 asynchronously, no rsp_valid, next write completes normally.
